// File: rtl/tmds_encoder_multi.sv
// Multi-lane DVI/HDMI TMDS 8b/10b encoder: stage 1 picks the XOR/XNOR transition-minimised word,
// stage 2 applies DC balancing, control-period symbols or the per-lane raw-symbol bypass.
module tmds_encoder_multi #(
   parameter int unsigned CHANNELS   = 3,
   parameter int unsigned RAW_ENABLE = 1
) (
   input  logic                     clk_pixel,
   input  logic                     resetn,
   input  logic [8*CHANNELS-1:0]    in_data,
   input  logic [2*CHANNELS-1:0]    in_ctrl,
   input  logic                     in_blank,
   input  logic [CHANNELS-1:0]      in_raw_en,
   input  logic [10*CHANNELS-1:0]   in_raw,
   output logic [10*CHANNELS-1:0]   out_symbol
);

   localparam bit RawOn = (RAW_ENABLE != 0);

   function automatic logic [3:0] f_ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      logic [7:0]        w_d;
      logic [3:0]        w_n1d;
      logic [8:0]        w_qm;
      logic [8:0]        r_qm;
      logic              r_blank;
      logic [1:0]        r_ctrl;
      logic              r_raw_en;
      logic [9:0]        r_raw;
      logic [3:0]        w_n1;
      logic [3:0]        w_n0;
      logic signed [4:0] w_bal;
      logic signed [4:0] r_cnt;
      logic signed [4:0] w_cnt_d;
      logic [9:0]        r_sym;
      logic [9:0]        w_sym_d;

      assign w_d = in_data[8*g +: 8];

      always_comb begin
         logic [8:0] v_qm;
         w_n1d   = f_ones8(w_d);
         v_qm    = '0;
         v_qm[0] = w_d[0];
         if (w_n1d > 4'd4 || (w_n1d == 4'd4 && !w_d[0])) begin
            for (int b = 1; b < 8; b++) v_qm[b] = ~(v_qm[b-1] ^ w_d[b]);
            v_qm[8] = 1'b0;
         end else begin
            for (int b = 1; b < 8; b++) v_qm[b] = v_qm[b-1] ^ w_d[b];
            v_qm[8] = 1'b1;
         end
         w_qm = v_qm;
      end

      always_ff @(posedge clk_pixel) begin
         if (!resetn) begin
            r_qm     <= '0;
            r_blank  <= 1'b1;
            r_ctrl   <= 2'b00;
            r_raw_en <= 1'b0;
            r_raw    <= '0;
         end else begin
            r_qm     <= w_qm;
            r_blank  <= in_blank;
            r_ctrl   <= in_ctrl[2*g +: 2];
            r_raw_en <= RawOn & in_raw_en[g];
            r_raw    <= in_raw[10*g +: 10];
         end
      end

      // w_bal is n1-n0 of the stage-1 word; all disparity math stays in 5-bit signed.
      always_comb begin
         w_n1    = f_ones8(r_qm[7:0]);
         w_n0    = 4'd8 - w_n1;
         w_bal   = $signed({1'b0, w_n1}) - $signed({1'b0, w_n0});
         w_sym_d = 10'h354;
         w_cnt_d = r_cnt;
         if (r_raw_en) begin
            w_sym_d = r_raw;
         end else if (r_blank) begin
            unique case (r_ctrl)
               2'b00:   w_sym_d = 10'h354;
               2'b01:   w_sym_d = 10'h0AB;
               2'b10:   w_sym_d = 10'h154;
               default: w_sym_d = 10'h2AB;
            endcase
            w_cnt_d = 5'sd0;
         end else if (r_cnt == 5'sd0 || w_n1 == w_n0) begin
            w_sym_d = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_d = r_qm[8] ? r_cnt + w_bal : r_cnt - w_bal;
         end else if ((r_cnt > 5'sd0 && w_n1 > w_n0) || (r_cnt < 5'sd0 && w_n0 > w_n1)) begin
            w_sym_d = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_d = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_bal;
         end else begin
            w_sym_d = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_d = r_cnt - (r_qm[8] ? 5'sd0 : 5'sd2) + w_bal;
         end
      end

      always_ff @(posedge clk_pixel) begin
         if (!resetn) begin
            r_sym <= 10'h354;
            r_cnt <= 5'sd0;
         end else begin
            r_sym <= w_sym_d;
            r_cnt <= w_cnt_d;
         end
      end

      assign out_symbol[10*g +: 10] = r_sym;
   end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi: directed scenarios plus a long random run, every cycle compared
// against a running-disparity model of the transmitted symbols.
module tb_tmds_encoder_multi;

   localparam int CH = 3;

   logic            clk_pixel = 1'b0;
   logic            resetn;
   logic [8*CH-1:0]  in_data;
   logic [2*CH-1:0]  in_ctrl;
   logic             in_blank;
   logic [CH-1:0]    in_raw_en;
   logic [10*CH-1:0] in_raw;
   logic [10*CH-1:0] out_symbol;

   int checks = 0;
   int errors = 0;

   tmds_encoder_multi #(
      .CHANNELS   (CH),
      .RAW_ENABLE (1)
   ) dut (
      .clk_pixel  (clk_pixel),
      .resetn     (resetn),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .in_blank   (in_blank),
      .in_raw_en  (in_raw_en),
      .in_raw     (in_raw),
      .out_symbol (out_symbol)
   );

   always #5 clk_pixel = ~clk_pixel;

   // Model: one slot of captured inputs, then the emitted symbol and per-lane running disparity.
   logic [7:0]  m_data  [CH];
   logic [1:0]  m_ctrl  [CH];
   logic        m_rawen [CH];
   logic [9:0]  m_raw   [CH];
   logic        m_blank;
   int          mcnt    [CH];
   logic [10*CH-1:0] mout;
   logic [9:0]  ctab [4];

   function automatic int ones(input logic [9:0] v);
      int n = 0;
      for (int i = 0; i < 10; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic logic [9:0] enc(input int l);
      logic [7:0] d;
      logic [7:0] qm;
      logic       q8;
      logic       inv;
      logic [9:0] sym;
      int         n1;
      if (m_rawen[l]) return m_raw[l];
      if (m_blank) begin
         mcnt[l] = 0;
         return ctab[m_ctrl[l]];
      end
      d  = m_data[l];
      q8 = !(ones({2'b00, d}) > 4 || (ones({2'b00, d}) == 4 && !d[0]));
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = q8 ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
      n1 = ones({2'b00, qm});
      if (mcnt[l] == 0 || n1 == 4) inv = !q8;
      else inv = ((mcnt[l] > 0) == (n1 > 4));
      sym = {inv, q8, inv ? ~qm : qm};
      // Running disparity is simply the ones-minus-zeros of everything sent so far.
      mcnt[l] += 2 * ones(sym) - 10;
      return sym;
   endfunction

   task automatic model_edge();
      if (!resetn) begin
         m_blank = 1'b1;
         for (int l = 0; l < CH; l++) begin
            m_ctrl[l] = 2'b00; m_rawen[l] = 1'b0; m_data[l] = 8'h00; mcnt[l] = 0;
            mout[10*l +: 10] = 10'h354;
         end
      end else begin
         for (int l = 0; l < CH; l++) mout[10*l +: 10] = enc(l);
         m_blank = in_blank;
         for (int l = 0; l < CH; l++) begin
            m_data[l]  = in_data[8*l +: 8];
            m_ctrl[l]  = in_ctrl[2*l +: 2];
            m_rawen[l] = in_raw_en[l];
            m_raw[l]   = in_raw[10*l +: 10];
         end
      end
   endtask

   task automatic check(input string tag, input logic [10*CH-1:0] obs,
                        input logic [10*CH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk_pixel);
      #1;
      check("pipe", out_symbol, mout);
   endtask

   initial begin
      logic [10*CH-1:0] all354;
      all354  = {CH{10'h354}};
      ctab[0] = 10'h354; ctab[1] = 10'h0AB; ctab[2] = 10'h154; ctab[3] = 10'h2AB;

      resetn = 1'b0; in_blank = 1'b1; in_ctrl = '0; in_data = '0; in_raw_en = '0; in_raw = '0;
      repeat (3) step();
      check("reset_354", out_symbol, all354);
      #3 resetn = 1'b1;
      repeat (4) step();
      check("idle_354", out_symbol, all354);

      // Three zero bytes: 0x100, 0x3FF, 0x100 as disparity swings -8, +2, -6.
      in_blank = 1'b0; in_data = '0;
      step();
      step(); check("zero_0", {20'd0, out_symbol[9:0]}, {20'd0, 10'h100});
      step(); check("zero_1", {20'd0, out_symbol[9:0]}, {20'd0, 10'h3FF});
      in_blank = 1'b1;
      step(); check("zero_2", {20'd0, out_symbol[9:0]}, {20'd0, 10'h100});
      step(); check("zero_blank", out_symbol, all354);

      // Control sweep on lane 0; each symbol lands two edges after it is driven.
      for (int i = 0; i < 4; i++) begin
         in_ctrl[1:0] = 2'(i);
         step();
         if (i > 0) check("ctrl_sweep", {20'd0, out_symbol[9:0]}, {20'd0, ctab[i-1]});
      end
      step(); check("ctrl_11", {20'd0, out_symbol[9:0]}, {20'd0, 10'h2AB});

      // Raw symbol dropped into a 0xFF stream, then raw beating blank on lane 1.
      in_ctrl = '0; in_blank = 1'b0; in_data = {CH{8'hFF}};
      repeat (5) step();
      in_raw_en = 3'b001; in_raw[9:0] = 10'h2CC;
      step();
      in_raw_en = '0;
      step(); check("raw_gap", {20'd0, out_symbol[9:0]}, {20'd0, 10'h2CC});
      repeat (5) step();
      in_blank = 1'b1; in_raw_en = 3'b010; in_raw[19:10] = 10'h155;
      step();
      in_blank = 1'b0; in_raw_en = '0;
      step(); check("raw_over_blank", {20'd0, out_symbol[19:10]}, {20'd0, 10'h155});
      repeat (4) step();

      // One-cycle reset mid-line.
      for (int i = 0; i < 4; i++) begin
         in_data = {8'($urandom), 8'($urandom), 8'($urandom)};
         step();
      end
      resetn = 1'b0;
      step(); check("midreset", out_symbol, all354);
      resetn = 1'b1; in_data = '0;
      step(); check("post_reset_slot", out_symbol, all354);
      step(); check("post_reset_cnt0", out_symbol, {CH{10'h100}});
      repeat (3) step();

      // Long random run with periodic blanking and sparse raw bypass.
      for (int c = 0; c < 10000; c++) begin
         in_blank = ((c % 800) < 12);
         for (int l = 0; l < CH; l++) begin
            in_data[8*l +: 8]   = 8'($urandom);
            in_ctrl[2*l +: 2]   = 2'($urandom);
            in_raw_en[l]        = ($urandom_range(0, 31) == 0);
            in_raw[10*l +: 10]  = 10'($urandom);
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmds_encoder_multi.md
TMDS_ENCODER_MULTI -- requirements
Module: tmds_encoder_multi

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent TMDS lanes; legal range 1..8.
REQ-002 Parameter RAW_ENABLE, default 1: 1 enables the raw-symbol bypass; 0 ties bypass off and removes its logic.
REQ-003 clk_pixel  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 in_data  input  8*CHANNELS  pixel byte per lane; lane i at [8i+7:8i].
REQ-006 in_ctrl  input  2*CHANNELS  control pair per lane; lane i at [2i+1:2i] (lane 0 carries {vsync,hsync}).
REQ-007 in_blank  input  1  1 = control period on all lanes, 0 = active video.
REQ-008 in_raw_en  input  CHANNELS  per-lane bypass select; has priority over in_blank.
REQ-009 in_raw  input  10*CHANNELS  per-lane literal symbol used when bypassed.
REQ-010 out_symbol  output  10*CHANNELS  encoded symbol per lane; bit 0 transmitted first.

Function
REQ-011 Every input is sampled on edge k; the corresponding out_symbol is presented after edge k+2, giving a fixed 2-cycle latency; all lanes stay aligned.
REQ-012 Stage 1 shall count the ones N1 in the data byte D.
REQ-013 If N1>4, or N1==4 with D[0]==0, stage 1 shall use XNOR: q_m[0]=D[0], q_m[i]=~(q_m[i-1]^D[i]), q_m[8]=0.
REQ-014 Otherwise stage 1 shall use XOR with q_m[8]=1.
REQ-015 Stage 1 shall register q_m[8:0], blank, ctrl and raw fields per lane.
REQ-016 Stage 2 shall hold a per-lane signed 5-bit disparity cnt; n1 and n0 count ones and zeros of q_m[7:0].
REQ-017 If cnt==0 or n1==n0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
REQ-018 In the REQ-017 case, cnt += (q_m[8] ? n1-n0 : n0-n1).
REQ-019 Else, if (cnt>0 and n1>n0) or (cnt<0 and n0>n1): out = {1, q_m[8], ~q_m[7:0]} and cnt += 2*q_m[8] + (n0-n1).
REQ-020 Else: out = {0, q_m[8], q_m[7:0]} and cnt += -2*(~q_m[8]) + (n1-n0).
REQ-021 cnt arithmetic shall be 5-bit two's complement; legal range is -10..+10, so it never wraps.
REQ-022 When blank is registered (and raw is not), out shall be chosen from ctrl: 00->10'b1101010100 (0x354), 01->0x0AB, 10->0x154, 11->0x2AB; cnt forced to 0.
REQ-023 When raw_en is registered for a lane, out = in_raw for that lane and cnt is held unchanged, regardless of in_blank.
REQ-024 Raw and encoded lanes may be mixed within one cycle; each lane is independent.
REQ-025 A transition from blank to active shall start encoding from cnt=0 with no bubble cycle.
REQ-026 RAW_ENABLE=0: in_raw_en and in_raw are ignored.

Reset
REQ-027 While resetn is low at an edge, every stage register shall load blank=1, ctrl=00, raw_en=0, q_m=0, and cnt=0.
REQ-028 While resetn is low at an edge, out_symbol shall load 0x354 on every lane.
REQ-029 Reset asserted mid-line shall abort in-flight pixels; the two pipeline slots emit 0x354 after release until new inputs reach the output.
REQ-030 Reset asserted mid-line shall be followed by no stale symbols.

Verification
REQ-031 Reset held 3 cycles, then released with in_blank=1 and ctrl=00 -> all lanes output 0x354 on every cycle; no X at any time.
REQ-032 in_blank=0, lane 0 fed 0x00 for 3 consecutive cycles -> outputs 0x100, 0x3FF, 0x100 at latencies 2, 3, 4; internal cnt goes -8, +2, -6.
REQ-033 in_blank=1 with ctrl swept 00/01/10/11 on lane 0 -> 0x354, 0x0AB, 0x154, 0x2AB, each appearing exactly 2 cycles after its input.
REQ-034 Active run of 0xFF, one cycle of in_raw_en=1 with in_raw=0x2CC, then 0xFF resumes -> 0x2CC appears in the 0xFF stream and disparity is continuous across the gap (checked against a reference model).
REQ-035 CHANNELS=3, each lane driven with a different random byte stream for 10000 cycles, blanking every 800 cycles -> bit-exact match to a behavioural model; |cnt| never exceeds 10.
REQ-036 resetn pulsed low for 1 cycle mid-active-line -> two cycles later 0x354 on all lanes; the first post-reset pixel encodes with cnt=0.
